// File: rtl/cmd_executor.sv
// cmd_executor: decodes collected W/R commands into register-file accesses and a one-byte UART response.
module cmd_executor #(
  parameter int          ADDR_W = 4,
  parameter logic [7:0]  CMD_WR = 8'h57,
  parameter logic [7:0]  CMD_RD = 8'h52
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_ready,
  input  logic [7:0]        cmd,
  input  logic [7:0]        addr,
  input  logic [7:0]        data,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic [7:0]        cmd_count,
  output logic [7:0]        err_count,
  output logic [7:0]        drop_count
);
  typedef enum logic [2:0] {IDLE, DECODE, RD_WAIT, TX_SEND, TX_HOLD} state_t;
  state_t     state;
  logic [7:0] cmd_q, resp, tx_last;
  logic       addr_ok;
  logic       is_wr, is_rd;
  assign is_wr    = addr_ok && cmd_q == CMD_WR;
  assign is_rd    = addr_ok && cmd_q == CMD_RD;
  assign reg_we   = state == DECODE && is_wr;
  assign tx_start = state == TX_SEND && !tx_busy;
  assign busy     = state != IDLE;
  // tx_data shows the new response only while it is being sent, else the previous one
  assign tx_data  = tx_start ? resp : tx_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= '0;
      addr_ok    <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      resp       <= '0;
      tx_last    <= '0;
      cmd_count  <= '0;
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      if (cmd_ready && state != IDLE && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      case (state)
        IDLE: if (cmd_ready) begin
          cmd_q     <= cmd;
          addr_ok   <= (addr >> ADDR_W) == 8'd0;
          reg_addr  <= addr[ADDR_W-1:0];
          reg_wdata <= data;
          cmd_count <= cmd_count + 8'd1;
          state     <= DECODE;
        end
        DECODE: begin
          resp      <= is_wr ? 8'h4B : 8'h45;
          err_count <= (is_wr || is_rd || err_count == 8'hFF) ? err_count : err_count + 8'd1;
          state     <= is_rd ? RD_WAIT : TX_SEND;
        end
        RD_WAIT: begin
          resp  <= reg_rdata;
          state <= TX_SEND;
        end
        TX_SEND: if (!tx_busy) begin
          tx_last <= resp;
          state   <= TX_HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cmd_executor.md
CMD_EXECUTOR -- requirements
Module: cmd_executor

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register-file address width (2^ADDR_W registers).
REQ-002 SHALL have parameter CMD_WR, default 8'h57, write opcode ('W').
REQ-003 SHALL have parameter CMD_RD, default 8'h52, read opcode ('R').
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_ready  input  1  one-cycle pulse: cmd/addr/data hold a complete command.
REQ-007 SHALL have ports cmd, addr, data  input  8 each  command fields from the byte collector.
REQ-008 SHALL have port reg_we  output  1  register-file write strobe, one cycle.
REQ-009 SHALL have port reg_addr  output  ADDR_W  register-file address.
REQ-010 SHALL have port reg_wdata  output  8  register-file write data.
REQ-011 SHALL have port reg_rdata  input  8  register-file read data, valid one cycle after reg_addr is presented.
REQ-012 SHALL have port tx_start  output  1  one-cycle pulse to UART transmitter.
REQ-013 SHALL have port tx_data  output  8  response byte, valid while tx_start is high.
REQ-014 SHALL have port tx_busy  input  1  transmitter busy; rises the cycle after tx_start.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have ports cmd_count, err_count, drop_count  output  8 each  statistics counters.

Function
REQ-017 SHALL implement states IDLE, DECODE, RD_WAIT, TX_SEND, TX_HOLD.
REQ-018 IDLE: on cmd_ready, latch cmd/addr/data, increment cmd_count (wraps 255->0), go DECODE.
REQ-019 Address valid iff addr[7:ADDR_W] == 0; reg_addr = addr[ADDR_W-1:0].
REQ-020 DECODE, cmd==CMD_WR and address valid: reg_we=1 for exactly this cycle with latched addr/data, response=8'h4B ('K'), go TX_SEND.
REQ-021 DECODE, cmd==CMD_RD and address valid: present reg_addr, go RD_WAIT.
REQ-022 RD_WAIT: capture reg_rdata as response, go TX_SEND.
REQ-023 DECODE, any other opcode or invalid address: response=8'h45 ('E'), err_count +1 saturating at 255, no reg_we, go TX_SEND.
REQ-024 TX_SEND: while tx_busy=1 remain; when tx_busy=0, pulse tx_start one cycle with tx_data=response, go TX_HOLD.
REQ-025 TX_HOLD: one cycle unconditionally (covers tx_busy rise latency), then IDLE.
REQ-026 Latency, idle transmitter: write cmd_ready at cycle 0 -> reg_we at cycle 1 -> tx_start at cycle 2; read -> tx_start at cycle 3.
REQ-027 cmd_ready while state != IDLE SHALL be dropped: no field latch, cmd_count unchanged, drop_count +1 saturating at 255.
REQ-028 cmd_ready in IDLE SHALL be accepted even if tx_busy=1; TX_SEND then waits.
REQ-029 reg_we SHALL never assert outside DECODE; tx_start never outside TX_SEND; at most one tx_start per accepted command.
REQ-030 tx_data SHALL hold the last response between transmissions.

Reset
REQ-031 On rst: state=IDLE; reg_we=0, tx_start=0, busy=0; reg_addr, reg_wdata, tx_data=0; all counters=0.
REQ-032 rst mid-command SHALL abort immediately: no reg_we or tx_start afterward for that command.
REQ-033 rst SHALL take priority over cmd_ready in the same cycle.

Verification
REQ-034 Write 57/03/A5, tx_busy=0 -> reg_we one cycle at cycle 1, addr 3, wdata A5; tx_start cycle 2, tx_data 4B; cmd_count=1.
REQ-035 Read 52/03/xx, reg_rdata=A5 -> tx_start cycle 3, tx_data A5; no reg_we.
REQ-036 Opcode 58 or write to addr 10 (ADDR_W=4) -> tx_data 45, no reg_we, err_count +1; 256 errors -> err_count stays FF.
REQ-037 tx_busy held high 20 cycles after DECODE -> tx_start delayed until first cycle tx_busy=0; exactly one pulse.
REQ-038 Second cmd_ready 1 cycle after first -> dropped, drop_count=1, first completes unchanged.
REQ-039 rst asserted in RD_WAIT -> no tx_start, outputs and counters at reset values next cycle.
